shift_detect: RTL and testbench
===============================

// Module: shift_detect
// PURPOSE
//  Inverse of the 8-bit barrel shifter: given an original byte and a shifted byte, finds the shift
//  amount and direction that produced it. Searches sequentially, one candidate per clock, behind a
//  start/done handshake. Used as the self-check companion of the shifter on the board test path.
// PARAMETERS
//  WIDTH     8   data width; shift amount width is $clog2(WIDTH)=3
//  NCAND     16  candidates = WIDTH amounts x 2 directions (derived, not overridable)
// PORTS
//  clk         in   1   single clock, rising edge
//  rst         in   1   synchronous, active-high reset
//  start       in   1   request; sampled only in IDLE
//  in_orig     in   8   original operand; latched on accepted start
//  in_shifted  in   8   shifted operand; latched on accepted start
//  busy        out  1   high in SEARCH and DONE
//  done        out  1   one-cycle pulse when the result is valid
//  found       out  1   1 = match found; valid from done, held until next accepted start
//  shift       out  3   matching amount; held like found
//  direction   out  1   matching direction (1 = left, 0 = right); held like found
// BEHAVIOUR
//  - Shift semantics: logical, zero fill, no rotate; dir 1 = in<<amt, dir 0 = in>>amt, result 8 bits.
//  - Reset: state=IDLE, idx=0, busy=0, done=0, found=0, shift=0, direction=0, latched operands=0.
//  - FSM IDLE -> SEARCH on start; SEARCH -> DONE on match or at idx==15; DONE -> IDLE unconditionally.
//  - Candidate order idx=0..15: amt=idx[3:1], dir=idx[0] (0R,0L,1R,1L,...,7L). First match wins,
//    so smallest amount wins, right before left on equal amount.
//  - Start accepted at edge E0 latches operands and sets idx=0. During each SEARCH cycle candidate
//    idx is compared against the latched shifted value. If candidate i matches, the edge E0+i+1
//    registers found=1, shift=amt, direction=dir, and done=1 for one cycle. Latency = i+1 cycles.
//  - No match after idx 15: at edge E0+16, found=0, shift=0, direction=0, done=1.
//  - start while busy is ignored and is not queued. start in the same cycle as rst: rst wins.
//  - rst during SEARCH/DONE aborts; all outputs return to reset values at that edge with no done pulse.
//  - Operand inputs may change freely after acceptance; only the latched copies are used.
//  - Results are registered; no combinational path from inputs to outputs.
// STRUCTURE
//  - Package shift_pkg: state enum {IDLE, SEARCH, DONE}, localparam WIDTH=8, NCAND=16, and the
//    function shift_op(data, amt, dir). The barrel shifter and its bench use the same function.
//  - One sub-module: barrel_sft, used as a combinational candidate generator
//    (in=orig_q, shift=idx[3:1], direction=idx[0]).
//  - Everything else is inline: idx counter, comparator, FSM, and result registers.
// TESTING
//  - orig=8'hAD, shifted=8'h40 -> found=1, shift=6, dir=1, done at 14 cycles after the start edge.
//  - orig=8'hAD, shifted=8'h2B -> found=1, shift=2, dir=0, latency 5.
//  - orig=8'hAD, shifted=8'hAD -> found=1, shift=0, dir=0, latency 1; then orig=8'h80,
//    shifted=8'h00 -> shift=1, dir=1 (1L beats 1R? no: 8'h80>>1=8'h40), latency 4.
//  - orig=8'h01, shifted=8'h03 -> found=0, shift=0, dir=0, done at 16 cycles; busy=0 on the next cycle.
//  - start pulsed again while busy with different operands -> ignored; original result returned.
//  - rst asserted on the 5th SEARCH cycle -> next edge busy=0, done=0, outputs=0; a new start
//    afterwards works normally.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared types and the reference shift operation for the barrel shifter and its inverse detector.
package shift_pkg;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned AW    = $clog2(WIDTH);
  localparam int unsigned NCAND = 2 * WIDTH;
  localparam int unsigned IW    = $clog2(NCAND);

  typedef enum logic [1:0] {
    StIdle,
    StSearch,
    StDone
  } state_e;

  // Logical shift with zero fill; dir 1 = left, dir 0 = right.
  function automatic logic [WIDTH-1:0] shift_op(input logic [WIDTH-1:0] data,
                                                input logic [AW-1:0]    amt,
                                                input logic             dir);
    return dir ? (data << amt) : (data >> amt);
  endfunction

endpackage

// File: rtl/barrel_sft.sv
// Combinational 8-bit logical barrel shifter; used here to generate search candidates.
module barrel_sft
  import shift_pkg::*;
(
  input  logic [WIDTH-1:0] in,
  input  logic [AW-1:0]    shift,
  input  logic             direction,
  output logic [WIDTH-1:0] out
);

  assign out = shift_op(in, shift, direction);

endmodule

// File: rtl/shift_detect.sv
// Recovers the shift amount/direction relating two bytes by trying one candidate per clock.
module shift_detect
  import shift_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] in_orig,
  input  logic [WIDTH-1:0] in_shifted,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic [AW-1:0]    shift,
  output logic             direction
);

  state_e           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] orig_q, orig_d;
  logic [WIDTH-1:0] shifted_q, shifted_d;
  logic             found_q, found_d;
  logic [AW-1:0]    shift_q, shift_d;
  logic             dir_q, dir_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] cand;
  logic             match;

  // Candidate order: amount in idx[3:1], direction in idx[0], so right is tried before left.
  barrel_sft u_cand (
    .in        (orig_q),
    .shift     (idx_q[IW-1:1]),
    .direction (idx_q[0]),
    .out       (cand)
  );

  assign match = (cand == shifted_q);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    orig_d    = orig_q;
    shifted_d = shifted_q;
    found_d   = found_q;
    shift_d   = shift_q;
    dir_d     = dir_q;
    done_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StSearch;
          idx_d     = '0;
          orig_d    = in_orig;
          shifted_d = in_shifted;
          found_d   = 1'b0;
          shift_d   = '0;
          dir_d     = 1'b0;
        end
      end
      StSearch: begin
        if (match) begin
          state_d = StDone;
          done_d  = 1'b1;
          found_d = 1'b1;
          shift_d = idx_q[IW-1:1];
          dir_d   = idx_q[0];
        end else if (idx_q == IW'(NCAND - 1)) begin
          state_d = StDone;
          done_d  = 1'b1;
          found_d = 1'b0;
          shift_d = '0;
          dir_d   = 1'b0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      orig_q    <= '0;
      shifted_q <= '0;
      found_q   <= 1'b0;
      shift_q   <= '0;
      dir_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      orig_q    <= orig_d;
      shifted_q <= shifted_d;
      found_q   <= found_d;
      shift_q   <= shift_d;
      dir_q     <= dir_d;
      done_q    <= done_d;
    end
  end

  assign busy      = (state_q != StIdle);
  assign done      = done_q;
  assign found     = found_q;
  assign shift     = shift_q;
  assign direction = dir_q;

endmodule

// File: tb/tb_shift_detect.sv
// Directed bench for shift_detect: latency-level reference model plus literal result checks.
module tb_shift_detect;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] in_orig;
  logic [7:0] in_shifted;
  logic       busy;
  logic       done;
  logic       found;
  logic [2:0] shift;
  logic       direction;

  int total = 0;
  int bad   = 0;

  shift_detect dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_orig    (in_orig),
    .in_shifted (in_shifted),
    .busy       (busy),
    .done       (done),
    .found      (found),
    .shift      (shift),
    .direction  (direction)
  );

  always #5 clk = ~clk;

  // Reference model: on accept, the answer and its latency are worked out directly by scanning
  // amounts 0..7 (right then left); the model then just counts down the latency.
  logic       m_busy, m_done, m_found, m_dir;
  logic [2:0] m_shift;
  int         m_cnt;
  logic       p_found, p_dir;
  logic [2:0] p_shift;

  always @(posedge clk) begin
    automatic int         lat = 16;
    automatic logic       f = 1'b0;
    automatic logic [2:0] a = 3'd0;
    automatic logic       d = 1'b0;
    if (rst) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_found <= 1'b0; m_shift <= 3'd0; m_dir <= 1'b0;
      m_cnt  <= 0;
    end else if (m_done) begin
      m_done <= 1'b0;
      m_busy <= 1'b0;
    end else if (m_busy) begin
      if (m_cnt == 1) begin
        m_done <= 1'b1; m_found <= p_found; m_shift <= p_shift; m_dir <= p_dir;
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end else if (start) begin
      for (int k = 0; k < 8 && !f; k++) begin
        if (((in_orig >> k) & 8'hFF) == in_shifted) begin
          f = 1'b1; a = 3'(k); d = 1'b0; lat = 2 * k + 1;
        end else if (((in_orig << k) & 8'hFF) == in_shifted) begin
          f = 1'b1; a = 3'(k); d = 1'b1; lat = 2 * k + 2;
        end
      end
      p_found <= f; p_shift <= a; p_dir <= d;
      m_busy  <= 1'b1; m_cnt <= lat;
      m_found <= 1'b0; m_shift <= 3'd0; m_dir <= 1'b0;
    end
  end

  // Cycle-by-cycle compare against the model once reset has been applied.
  logic cmp_en = 1'b0;
  always @(negedge clk) begin
    if (cmp_en) begin
      total++;
      if ({busy, done, found, shift, direction} !== {m_busy, m_done, m_found, m_shift, m_dir}) begin
        bad++;
        $display("FAIL model_cmp t=%0t got b=%b d=%b f=%b s=%0d dir=%b want b=%b d=%b f=%b s=%0d dir=%b",
                 $time, busy, done, found, shift, direction,
                 m_busy, m_done, m_found, m_shift, m_dir);
      end
    end
  end

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  // Waits for done with a cycle budget; returns measured latency (-1 on timeout).
  task automatic wait_done(output int lat);
    lat = -1;
    for (int n = 1; n <= 24; n++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic run_case(input string name, input logic [7:0] o, input logic [7:0] s,
                          input int ef, input int es, input int ed, input int elat);
    int lat;
    @(negedge clk);
    start = 1'b1; in_orig = o; in_shifted = s;
    @(negedge clk);
    start = 1'b0; in_orig = ~o; in_shifted = ~s;
    wait_done(lat);
    check({name, "_lat"}, lat, elat);
    check({name, "_found"}, int'(found), ef);
    check({name, "_shift"}, int'(shift), es);
    check({name, "_dir"}, int'(direction), ed);
    @(negedge clk);
    check({name, "_idle_after"}, int'(busy), 0);
    check({name, "_held_shift"}, int'(shift), es);
  endtask

  initial begin
    int lat;
    rst = 1'b1; start = 1'b0; in_orig = 8'h00; in_shifted = 8'h00;
    repeat (2) @(negedge clk);
    cmp_en = 1'b1;
    check("reset_busy", int'(busy), 0);
    check("reset_outs", int'({done, found, shift, direction}), 0);
    rst = 1'b0;

    run_case("ad_40", 8'hAD, 8'h40, 1, 6, 1, 14);
    run_case("ad_2b", 8'hAD, 8'h2B, 1, 2, 0, 5);
    run_case("ad_ad", 8'hAD, 8'hAD, 1, 0, 0, 1);
    run_case("80_00", 8'h80, 8'h00, 1, 1, 1, 4);
    run_case("01_03", 8'h01, 8'h03, 0, 0, 0, 16);

    // start while busy with operands that would match immediately must be ignored
    @(negedge clk);
    start = 1'b1; in_orig = 8'hAD; in_shifted = 8'h2B;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; in_orig = 8'h11; in_shifted = 8'h11;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat);
    check("busy_ign_lat", lat, 3);
    check("busy_ign_shift", int'(shift), 2);
    check("busy_ign_found", int'(found), 1);
    @(negedge clk);

    // rst on the 5th search cycle aborts with no done pulse
    start = 1'b1; in_orig = 8'h01; in_shifted = 8'h03;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_outs", int'({done, found, shift, direction}), 0);
    run_case("after_abort", 8'hAD, 8'h40, 1, 6, 1, 14);

    // start coincident with rst: rst wins
    @(negedge clk);
    start = 1'b1; rst = 1'b1; in_orig = 8'hAD; in_shifted = 8'hAD;
    @(negedge clk);
    start = 1'b0; rst = 1'b0;
    check("rst_wins_busy", int'(busy), 0);
    repeat (2) @(negedge clk);
    check("rst_wins_idle", int'(busy), 0);

    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
